// File: rtl/datapath_unit.sv
// Execution and memory responder for the CU: latches one issued operation per start
// strobe, runs it through the ALU or a small data memory and returns the write-back value.
module datapath_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  busy,
  output logic                  done,
  output logic                  zero,
  output logic                  carry
);

  // state | meaning
  // IDLE  | waiting for start; holds done high for the cycle after WB
  // EXEC  | ALU result and memory address computed from latched operands
  // MEM   | data memory store or load (memory ops only)
  // WB    | result2/flags written back, done raised
  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, off_q;
  logic [3:0]            opc_q;
  logic                  sel1_q, sel3_q, wr_q;
  logic [DATA_WIDTH-1:0] alu_q, rd_q;
  logic                  alu_c_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] b_op;
  logic [DATA_WIDTH:0]   sum9, diff9, inc9, dec9;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_cy;

  always_comb begin
    b_op    = sel3_q ? off_q : op2_q;
    sum9    = {1'b0, op1_q} + {1'b0, b_op};
    diff9   = {1'b0, op1_q} - {1'b0, b_op};
    inc9    = {1'b0, op1_q} + (DATA_WIDTH+1)'(1);
    dec9    = {1'b0, op1_q} - (DATA_WIDTH+1)'(1);
    alu_res = '0;
    alu_cy  = 1'b0;
    case (opc_q)
      4'h0: begin alu_res = sum9[DATA_WIDTH-1:0];  alu_cy = sum9[DATA_WIDTH];  end
      4'h1: begin alu_res = diff9[DATA_WIDTH-1:0]; alu_cy = diff9[DATA_WIDTH]; end
      4'h2: alu_res = op1_q & b_op;
      4'h3: alu_res = op1_q | b_op;
      4'h4: alu_res = op1_q ^ b_op;
      4'h5: alu_res = ~op1_q;
      4'h6: alu_res = op1_q << b_op[2:0];
      4'h7: alu_res = op1_q >> b_op[2:0];
      4'h8: begin alu_res = inc9[DATA_WIDTH-1:0];  alu_cy = inc9[DATA_WIDTH];  end
      4'h9: begin alu_res = dec9[DATA_WIDTH-1:0];  alu_cy = dec9[DATA_WIDTH];  end
      4'hA: alu_res = op1_q;
      4'hB: alu_res = b_op;
      4'hC: alu_res = (op1_q < b_op) ? DATA_WIDTH'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      result2 <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      off_q   <= '0;
      opc_q   <= '0;
      sel1_q  <= 1'b0;
      sel3_q  <= 1'b0;
      wr_q    <= 1'b0;
      alu_q   <= '0;
      alu_c_q <= 1'b0;
      rd_q    <= '0;
      addr_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op1_q  <= operand1;
            op2_q  <= operand2;
            off_q  <= offset;
            opc_q  <= opcode;
            sel1_q <= sel1;
            sel3_q <= sel3;
            wr_q   <= w_r;
            busy   <= 1'b1;
            state  <= EXEC;
          end else begin
            busy <= 1'b0;
          end
        end
        EXEC: begin
          alu_q   <= alu_res;
          alu_c_q <= alu_cy;
          // address wraps within the memory: only the low bits of the sum are kept
          addr_q  <= ADDR_BITS'(op1_q + off_q);
          state   <= sel1_q ? WB : MEM;
        end
        MEM: begin
          if (wr_q) mem[addr_q] <= op2_q;
          else      rd_q        <= mem[addr_q];
          state <= WB;
        end
        WB: begin
          done  <= 1'b1;
          state <= IDLE;
          if (sel1_q) begin
            if (opc_q != 4'hF) begin
              result2 <= alu_q;
              zero    <= (alu_q == '0);
              carry   <= alu_c_q;
            end
          end else begin
            result2 <= wr_q ? op2_q : rd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Randomized self-checking bench for datapath_unit against a behavioural model of the
// ALU/memory rules, plus directed cases for flags, address wrap, protocol and reset.
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] operand1 = '0, operand2 = '0, offset = '0;
  logic [3:0] opcode = '0;
  logic       sel1 = 1'b0, sel3 = 1'b0, w_r = 1'b0;
  logic [7:0] result2;
  logic       busy, done, zero, carry;

  int checks = 0;
  int failures = 0;

  // reference state
  int m_mem [32];
  int m_res = 0, m_zero = 0, m_carry = 0;

  datapath_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .operand1(operand1), .operand2(operand2), .offset(offset),
    .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .result2(result2), .busy(busy), .done(done), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // spec-level ALU: plain integer arithmetic modulo 256
  task automatic alu_model(input int a, input int b, input int op, output int r, output int c);
    c = 0;
    case (op)
      0:  begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  r = (a * (1 << (b % 8))) % 256;
      7:  r = a / (1 << (b % 8));
      8:  begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
      9:  begin r = (a + 255) % 256; c = (a == 0) ? 1 : 0; end
      10: r = a;
      11: r = b;
      12: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
  endtask

  task automatic run_op(input int a, input int b, input int off, input int op,
                        input bit s1, input bit s3, input bit wr, input bit hold);
    int r, c, addr, lat, exp_lat;
    if (s1) begin
      alu_model(a, s3 ? off : b, op, r, c);
      if (op != 15) begin
        m_res = r; m_zero = (r == 0) ? 1 : 0; m_carry = c;
      end
    end else begin
      addr = (a + off) % 32;
      if (wr) begin m_mem[addr] = b; m_res = b; end
      else m_res = m_mem[addr];
    end
    exp_lat = s1 ? 2 : 3;

    @(negedge clk);
    operand1 = 8'(a); operand2 = 8'(b); offset = 8'(off); opcode = 4'(op);
    sel1 = s1; sel3 = s3; w_r = wr; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_on", busy, 1);
    @(negedge clk);
    if (hold) begin
      operand1 = ~operand1; operand2 = ~operand2; offset = ~offset; opcode = 4'h4;
    end else start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      chk("busy_held", busy, 1);
    end while (!done && lat < 8);
    chk("latency", lat, exp_lat);
    chk("result2", result2, m_res);
    chk("zero", zero, m_zero);
    chk("carry", carry, m_carry);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_res = 0; m_zero = 0; m_carry = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result2", result2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    @(negedge clk) rst = 1'b1;

    // directed cases
    run_op(5, 3, 0, 0, 1, 0, 0, 0);
    chk("add_5_3", result2, 8);
    run_op(200, 100, 0, 0, 1, 0, 0, 0);
    chk("add_wrap", result2, 44);
    chk("add_wrap_c", carry, 1);
    run_op(3, 3, 0, 1, 1, 0, 0, 0);
    chk("sub_zero", zero, 1);
    run_op(2, 5, 0, 1, 1, 0, 0, 0);
    chk("sub_borrow", result2, 253);
    run_op(4, 8'hAA, 3, 0, 0, 1, 1, 0);
    run_op(4, 0, 3, 0, 0, 1, 0, 0);
    chk("load_aa", result2, 8'hAA);
    run_op(8, 0, 0, 0, 0, 1, 0, 0);
    run_op(30, 8'h5C, 5, 0, 0, 1, 1, 0);
    run_op(0, 0, 3, 0, 0, 1, 0, 0);
    chk("wrap_load", result2, 8'h5C);
    run_op(5, 3, 0, 0, 1, 0, 0, 1);
    chk("hold_start", result2, 8);
    run_op(1, 1, 0, 15, 1, 0, 0, 0);
    chk("nop_keep", result2, 8);

    // reset while the store sits in MEM
    @(negedge clk);
    operand1 = 8'd9; operand2 = 8'h77; offset = 8'd0; opcode = 4'h0;
    sel1 = 1'b0; sel3 = 1'b1; w_r = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_result2", result2, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    run_op(9, 0, 0, 0, 0, 1, 0, 0);
    chk("mid_rst_load", result2, 0);

    // randomized operations
    for (int n = 0; n < 200; n++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
